// File: rtl/fifo_burst_rd_ctrl.sv
// Read-side burst scheduler for the DMA staging FIFO: negotiates a burst with the
// DMA engine, then drains exactly the granted words onto a valid/ready stream.
module fifo_burst_rd_ctrl #(
  parameter int DATA_WIDTH  = 128,
  parameter int LEVEL_WIDTH = 11,
  parameter int BURST_LEN   = 32,
  parameter int TIMEOUT     = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_level,
  output logic                   burst_req,
  output logic [LEVEL_WIDTH-1:0] burst_len,
  input  logic                   burst_ack,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic [15:0]            burst_cnt,
  output logic [1:0]             dbg_state
);

  // Handshakes: a stream word transfers on any clk edge where m_valid & m_ready;
  // burst_req stays high until the first edge that samples burst_ack=1.

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]       TMR_MAX  = TMR_W'(TIMEOUT - 1);
  localparam logic [LEVEL_WIDTH-1:0] FULL_LEN = LEVEL_WIDTH'(BURST_LEN);

  logic [1:0]             state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [LEVEL_WIDTH-1:0] burst_len_q, burst_len_d;
  logic [LEVEL_WIDTH-1:0] rem_q, rem_d;
  logic [LEVEL_WIDTH-1:0] sent_q, sent_d;
  logic                   inflight_q, inflight_d;
  logic [1:0]             occ_q, occ_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [15:0]            burst_cnt_q, burst_cnt_d;
  logic [DATA_WIDTH-1:0]  buf_q [2];
  logic [DATA_WIDTH-1:0]  buf_d [2];

  logic       pop;
  logic       rd_en;
  logic [1:0] occ_sum;

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf_q[rd_ptr_q];
  assign m_last    = m_valid & (sent_q == burst_len_q - LEVEL_WIDTH'(1));
  assign pop       = m_valid & m_ready;
  assign occ_sum   = occ_q + 2'(inflight_q);
  // Reads may only be issued if the word will find a free buffer slot on arrival.
  assign rd_en     = (state_q == ST_XFER) & (rem_q != '0) & ~fifo_rd_empty &
                     ((occ_sum < 2'd2) | pop);
  assign fifo_rd_en = rd_en;
  assign burst_req = (state_q == ST_REQ);
  assign burst_len = burst_len_q;
  assign busy      = (state_q != ST_IDLE);
  assign burst_cnt = burst_cnt_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    burst_len_d = burst_len_q;
    rem_d       = rem_q;
    sent_d      = sent_q;
    inflight_d  = rd_en;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    burst_cnt_d = burst_cnt_q;
    buf_d       = buf_q;
    occ_d       = occ_q + 2'(inflight_q) - 2'(pop);

    if (inflight_q) begin
      buf_d[wr_ptr_q] = fifo_rd_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      sent_d   = sent_q + LEVEL_WIDTH'(1);
    end
    if (rd_en) begin
      rem_d = rem_q - LEVEL_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (enable && (fifo_rd_level != '0) && (fifo_rd_level < FULL_LEN)) begin
          timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
        end else begin
          timer_d = '0;
        end
        // Full burst wins; the level check keeps a partial burst from ever being 0.
        if (enable && (fifo_rd_level >= FULL_LEN)) begin
          state_d     = ST_REQ;
          burst_len_d = FULL_LEN;
          timer_d     = '0;
        end else if (enable && (timer_q == TMR_MAX) && (fifo_rd_level != '0)) begin
          state_d     = ST_REQ;
          burst_len_d = fifo_rd_level;
          timer_d     = '0;
        end
      end
      ST_REQ: begin
        if (burst_ack) begin
          state_d = ST_XFER;
          rem_d   = burst_len_q;
          sent_d  = '0;
        end
      end
      ST_XFER: begin
        if (pop && m_last) begin
          state_d     = ST_IDLE;
          burst_cnt_d = burst_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      burst_len_q <= '0;
      rem_q       <= '0;
      sent_q      <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      burst_cnt_q <= 16'd0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      burst_len_q <= burst_len_d;
      rem_q       <= rem_d;
      sent_q      <= sent_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      buf_q[0]    <= buf_d[0];
      buf_q[1]    <= buf_d[1];
    end
  end

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Directed bench for fifo_burst_rd_ctrl: a behavioural FIFO and DMA responder feed
// the DUT, and a negedge monitor scores stream beats and burst requests.
module tb_fifo_burst_rd_ctrl;
  localparam int DW = 128;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_empty = 1'b1;
  logic [LW-1:0] fifo_rd_level = '0;
  logic          burst_req;
  logic [LW-1:0] burst_len;
  logic          burst_ack = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic [15:0]   burst_cnt;
  logic [1:0]    dbg_state;

  fifo_burst_rd_ctrl #(
    .DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .BURST_LEN(32), .TIMEOUT(256)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_level(fifo_rd_level),
    .burst_req(burst_req), .burst_len(burst_len), .burst_ack(burst_ack),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .burst_cnt(burst_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int errors  = 0;
  logic [DW:0]   exp_q[$];      // {last, data}
  logic [LW-1:0] exp_len_q[$];
  logic [DW-1:0] fifo_q[$];
  int level_bias = 0;
  int pop_cnt = 0;
  int req_seen = 0;
  int ready_mode = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic update_flags();
    fifo_rd_level = LW'(fifo_q.size() + level_bias);
    fifo_rd_empty = (fifo_q.size() == 0);
  endtask

  // ---------------- environment models ----------------
  // FIFO read side: data appears one cycle after the read strobe.
  initial begin
    logic rd;
    forever begin
      @(posedge clk);
      rd = fifo_rd_en;
      #1;
      if (rd && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
      update_flags();
    end
  end

  // DMA engine: acknowledges two cycles after it first sees the request.
  initial begin
    int req_age;
    req_age = 0;
    forever begin
      @(posedge clk);
      #1;
      if (burst_req) req_age++;
      else req_age = 0;
      burst_ack = (req_age == 2);
    end
  end

  // Sink: always ready, or toggling 1/0 every cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = (ready_mode != 0) ? ~m_ready : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic          prev_req;
    logic          stall_prev;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    int            outstanding;
    logic          pop;
    logic [DW:0]   e;
    prev_req = 1'b0; stall_prev = 1'b0; stall_data = '0; stall_last = 1'b0;
    outstanding = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0; stall_prev = 1'b0; outstanding = 0;
      end else begin
        pop = m_valid & m_ready;
        if (burst_req && !prev_req) begin
          req_seen++;
          if (exp_len_q.size() == 0) begin
            vectors++; errors++;
            $display("FAIL unexpected_req: got burst_len %0d expected no request", burst_len);
          end else begin
            chk("burst_len", burst_len, exp_len_q.pop_front());
          end
        end
        if (stall_prev) chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, stall_last, stall_data});
        if (fifo_rd_en) chk("rd_en_gate", (outstanding < 2) || pop, 1);
        if (pop) begin
          pop_cnt++;
          if (exp_q.size() == 0) begin
            vectors++; errors++;
            $display("FAIL unexpected_beat: got %0h expected no beat", {m_last, m_data});
          end else begin
            e = exp_q.pop_front();
            chk("beat", {m_last, m_data}, e);
          end
        end
        outstanding = outstanding + (fifo_rd_en ? 1 : 0) - (pop ? 1 : 0);
        stall_prev = m_valid & ~m_ready;
        stall_data = m_data;
        stall_last = m_last;
        prev_req   = burst_req;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] tag, input int start, input int n, input int blen);
    logic [DW-1:0] d;
    for (int i = start; i < start + n; i++) begin
      d = {tag, 24'hC0FFEE, 64'h0, 32'(i)};
      fifo_q.push_back(d);
      exp_q.push_back({((i % blen) == blen - 1), d});
    end
    update_flags();
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    chk(name, n < max_cycles, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    repeat (3) tick();
    chk("reset_outputs", {fifo_rd_en, burst_req, burst_len, m_valid, m_data, m_last,
                          busy, burst_cnt, dbg_state}, 0);
    rst = 1'b0;
    enable = 1'b1;
    tick();

    // T1: full burst, sink always ready
    exp_len_q.push_back(LW'(32));
    fill(8'h01, 0, 32, 32);
    wait_done("t1_done", 300);
    chk("t1_burst_cnt", burst_cnt, 16'd1);

    // T2: 5 words then silence -> partial burst after the idle timeout
    exp_len_q.push_back(LW'(5));
    fill(8'h02, 0, 5, 5);
    n = 0;
    while (!burst_req && n < 400) begin
      tick();
      n++;
    end
    chk("t2_req_delay", n, 256);
    wait_done("t2_done", 200);
    chk("t2_burst_cnt", burst_cnt, 16'd2);

    // T3: full burst against a toggling sink
    ready_mode = 1;
    exp_len_q.push_back(LW'(32));
    fill(8'h03, 0, 32, 32);
    wait_done("t3_done", 400);
    ready_mode = 0;
    tick();
    chk("t3_burst_cnt", burst_cnt, 16'd3);

    // T4: level reports 32 but only 20 words are readable yet
    pop_cnt = 0;
    level_bias = 12;
    exp_len_q.push_back(LW'(32));
    fill(8'h04, 0, 20, 32);
    n = 0;
    while (pop_cnt < 20 && n < 300) begin
      tick();
      n++;
    end
    chk("t4_first20", pop_cnt, 20);
    for (int i = 0; i < 10; i++) begin
      chk("t4_stall", {m_valid, busy}, 2'b01);
      tick();
    end
    level_bias = 0;
    fill(8'h04, 20, 12, 32);
    wait_done("t4_done", 300);
    chk("t4_burst_cnt", burst_cnt, 16'd4);

    // T5: reset in the middle of a burst, then a clean refill
    pop_cnt = 0;
    exp_len_q.push_back(LW'(32));
    fill(8'h05, 0, 32, 32);
    n = 0;
    while (pop_cnt < 10 && n < 300) begin
      tick();
      n++;
    end
    chk("t5_reach_beat10", pop_cnt >= 10, 1);
    rst = 1'b1;
    #1;
    chk("t5_reset_outputs", {fifo_rd_en, burst_req, burst_len, m_valid, m_data, m_last,
                             busy, burst_cnt, dbg_state}, 0);
    fifo_q.delete();
    exp_q.delete();
    exp_len_q.delete();
    level_bias = 0;
    update_flags();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    exp_len_q.push_back(LW'(32));
    fill(8'h06, 0, 32, 32);
    wait_done("t5_done", 300);
    chk("t5_burst_cnt", burst_cnt, 16'd1);

    // T6: level 64 held off by enable, then two back-to-back full bursts
    enable = 1'b0;
    req_seen = 0;
    fill(8'h07, 0, 64, 32);
    repeat (300) tick();
    chk("t6_no_req", req_seen, 0);
    exp_len_q.push_back(LW'(32));
    exp_len_q.push_back(LW'(32));
    enable = 1'b1;
    wait_done("t6_done", 600);
    chk("t6_req_count", req_seen, 2);
    chk("t6_burst_cnt", burst_cnt, 16'd3);

    repeat (5) tick();
    chk("final_exp_empty", exp_q.size(), 0);
    chk("final_len_empty", exp_len_q.size(), 0);
    chk("final_idle", {busy, m_valid, fifo_rd_level}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
